// File: rtl/uart_cmd_frame_parser_if.sv
// Byte-stream input and decoded-command output bundle of the UART command-frame parser.
// The receiver side drives Flag_Rx/UART_Rx; the parser drives everything else.
interface uart_cmd_frame_parser_if #(
  parameter int unsigned MAX_PAYLOAD = 8
);
  localparam int unsigned PW = $clog2(MAX_PAYLOAD + 1);

  logic                     Flag_Rx;
  logic [7:0]               UART_Rx;
  logic                     cmd_valid;
  logic [7:0]               cmd_code;
  logic [PW-1:0]            payload_len;
  logic [8*MAX_PAYLOAD-1:0] payload;
  logic                     frame_err;
  logic [1:0]               err_code;
  logic                     busy;

  modport master (
    output Flag_Rx, UART_Rx,
    input  cmd_valid, cmd_code, payload_len, payload, frame_err, err_code, busy
  );

  modport slave (
    input  Flag_Rx, UART_Rx,
    output cmd_valid, cmd_code, payload_len, payload, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_cmd_frame_parser.sv
// Parses HEADER, L, CMD, payload, FOOTER frames from a UART byte strobe and
// publishes the command and payload atomically, or an error strobe with its cause.
module uart_cmd_frame_parser #(
  parameter logic [7:0]  HEADER         = 8'hFE,
  parameter logic [7:0]  FOOTER         = 8'hEF,
  parameter int unsigned MAX_PAYLOAD    = 8,
  parameter logic [7:0]  CMD_MAX        = 8'd15,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic                    clk,
  input logic                    rst,
  uart_cmd_frame_parser_if.slave bus
);

  localparam int unsigned PW = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned IW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_FOOT = 3'd4;

  localparam logic [1:0] E_TIMEOUT = 2'd0;
  localparam logic [1:0] E_LEN     = 2'd1;
  localparam logic [1:0] E_CMD     = 2'd2;
  localparam logic [1:0] E_FOOT    = 2'd3;

  logic [2:0]    state;
  logic [TW-1:0] tmo_cnt;
  logic [PW-1:0] plen;   // payload byte count of the frame in flight (L-1)
  logic [PW-1:0] idx;
  logic [7:0]    sh_cmd;
  logic [7:0]    sh_buf [MAX_PAYLOAD];
  logic [8*MAX_PAYLOAD-1:0] sh_packed;

  always_comb begin
    sh_packed = '0;
    for (int i = 0; i < int'(MAX_PAYLOAD); i++) sh_packed[8*i +: 8] = sh_buf[i];
  end

  // NOTE: all state below is sequential, so every assignment in this block is
  // non-blocking; later assignments in the same cycle override earlier defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      tmo_cnt         <= '0;
      plen            <= '0;
      idx             <= '0;
      sh_cmd          <= '0;
      // NOTE: the shadow buffer is a handful of flops rather than a RAM, so it is
      // reset with everything else and unused slots are guaranteed to read 0.
      sh_buf          <= '{default: '0};
      bus.cmd_valid   <= 1'b0;
      bus.cmd_code    <= '0;
      bus.payload_len <= '0;
      bus.payload     <= '0;
      bus.frame_err   <= 1'b0;
      bus.err_code    <= E_TIMEOUT;
      bus.busy        <= 1'b0;
    end else begin
      bus.cmd_valid <= 1'b0;
      bus.frame_err <= 1'b0;

      if (bus.Flag_Rx) begin
        // A byte always beats a timeout landing on the same cycle.
        tmo_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (bus.UART_Rx == HEADER) begin
              state    <= S_LEN;
              bus.busy <= 1'b1;
              sh_buf   <= '{default: '0};
            end
          end
          S_LEN: begin
            if (bus.UART_Rx == 8'd0 || 32'(bus.UART_Rx) > MAX_PAYLOAD + 1) begin
              state         <= S_IDLE;
              bus.busy      <= 1'b0;
              bus.frame_err <= 1'b1;
              bus.err_code  <= E_LEN;
            end else begin
              plen  <= PW'(bus.UART_Rx - 8'd1);
              state <= S_CMD;
            end
          end
          S_CMD: begin
            if (bus.UART_Rx > CMD_MAX) begin
              state         <= S_IDLE;
              bus.busy      <= 1'b0;
              bus.frame_err <= 1'b1;
              bus.err_code  <= E_CMD;
            end else begin
              sh_cmd <= bus.UART_Rx;
              idx    <= '0;
              state  <= (plen == '0) ? S_FOOT : S_DATA;
            end
          end
          S_DATA: begin
            sh_buf[IW'(idx)] <= bus.UART_Rx;
            idx              <= idx + PW'(1);
            if (idx + PW'(1) == plen) state <= S_FOOT;
          end
          S_FOOT: begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
            if (bus.UART_Rx == FOOTER) begin
              bus.cmd_valid   <= 1'b1;
              bus.cmd_code    <= sh_cmd;
              bus.payload_len <= plen;
              bus.payload     <= sh_packed;
            end else begin
              bus.frame_err <= 1'b1;
              bus.err_code  <= E_FOOT;
            end
          end
          default: begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end else if (state != S_IDLE) begin
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state         <= S_IDLE;
          tmo_cnt       <= '0;
          bus.busy      <= 1'b0;
          bus.frame_err <= 1'b1;
          bus.err_code  <= E_TIMEOUT;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// Directed bench for uart_cmd_frame_parser with MAX_PAYLOAD=8 and TIMEOUT_CYCLES=20;
// inputs change on the falling edge and outputs are sampled there too.
module tb_uart_cmd_frame_parser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  // Model of the last good frame, which the outputs must hold through errors.
  logic [7:0]  exp_code = 8'h00;
  logic [3:0]  exp_len  = 4'd0;
  logic [63:0] exp_pl   = 64'h0;

  always #5 clk = ~clk;

  uart_cmd_frame_parser_if #(.MAX_PAYLOAD(8)) bus ();

  uart_cmd_frame_parser #(
    .HEADER(8'hFE), .FOOTER(8'hEF), .MAX_PAYLOAD(8), .CMD_MAX(8'd15), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe starting at a falling edge; returns on the next falling edge,
  // so consecutive calls give back-to-back strobes.
  task automatic send(input logic [7:0] b);
    bus.Flag_Rx = 1'b1;
    bus.UART_Rx = b;
    @(negedge clk);
    bus.Flag_Rx = 1'b0;
    bus.UART_Rx = 8'h00;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] code,
                              input logic [3:0] len, input logic [63:0] pl);
    exp_code = code;
    exp_len  = len;
    exp_pl   = pl;
    check({tag, ".cmd_valid"}, 64'(bus.cmd_valid), 64'd1);
    check({tag, ".frame_err"}, 64'(bus.frame_err), 64'd0);
    check({tag, ".cmd_code"},  64'(bus.cmd_code), 64'(exp_code));
    check({tag, ".len"},       64'(bus.payload_len), 64'(exp_len));
    check({tag, ".payload"},   bus.payload, exp_pl);
    check({tag, ".busy"},      64'(bus.busy), 64'd0);
  endtask

  task automatic expect_err(input string tag, input logic [1:0] code);
    check({tag, ".frame_err"}, 64'(bus.frame_err), 64'd1);
    check({tag, ".err_code"},  64'(bus.err_code), 64'(code));
    check({tag, ".cmd_valid"}, 64'(bus.cmd_valid), 64'd0);
    check({tag, ".busy"},      64'(bus.busy), 64'd0);
    check({tag, ".hold_code"}, 64'(bus.cmd_code), 64'(exp_code));
    check({tag, ".hold_len"},  64'(bus.payload_len), 64'(exp_len));
    check({tag, ".hold_pl"},   bus.payload, exp_pl);
    @(negedge clk);
    check({tag, ".err_pulse"}, 64'(bus.frame_err), 64'd0);
  endtask

  initial begin
    logic seen;
    bus.Flag_Rx = 1'b0;
    bus.UART_Rx = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.cmd_valid", 64'(bus.cmd_valid), 64'd0);
    check("rst.frame_err", 64'(bus.frame_err), 64'd0);
    check("rst.err_code",  64'(bus.err_code), 64'd0);
    check("rst.cmd_code",  64'(bus.cmd_code), 64'd0);
    check("rst.len",       64'(bus.payload_len), 64'd0);
    check("rst.payload",   bus.payload, 64'd0);
    check("rst.busy",      64'(bus.busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Minimal frame
    send(8'hFE);
    check("min.busy_rise", 64'(bus.busy), 64'd1);
    send(8'h01);
    send(8'h03);
    check("min.no_early_valid", 64'(bus.cmd_valid), 64'd0);
    send(8'hEF);
    expect_frame("min", 8'h03, 4'd0, 64'h0);
    @(negedge clk);
    check("min.valid_pulse", 64'(bus.cmd_valid), 64'd0);

    // Full frame followed immediately by a one-byte-payload frame
    send(8'hFE); send(8'h09); send(8'h05);
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i));
    send(8'hEF);
    expect_frame("full", 8'h05, 4'd8, 64'h1817_1615_1413_1211);
    send(8'hFE); send(8'h02); send(8'h01); send(8'hAA); send(8'hEF);
    expect_frame("b2b", 8'h01, 4'd1, 64'h0000_0000_0000_00AA);
    @(negedge clk);

    // Error cases, all keeping the previous good frame
    send(8'hFE); send(8'h00);
    expect_err("len0", 2'd1);
    send(8'hFE); send(8'h0A);
    expect_err("len10", 2'd1);
    send(8'hFE); send(8'h01); send(8'h10);
    expect_err("badcmd", 2'd2);
    send(8'hFE); send(8'h01); send(8'h03); send(8'hEE);
    expect_err("badfoot", 2'd3);

    // Timeout: error lands 20 cycles after the last strobe
    send(8'hFE); send(8'h02);
    seen = 1'b0;
    repeat (19) begin
      @(negedge clk);
      seen = seen | bus.frame_err;
    end
    check("tmo.no_early_err", 64'(seen), 64'd0);
    check("tmo.busy_held",    64'(bus.busy), 64'd1);
    @(negedge clk);
    expect_err("tmo", 2'd0);

    // Byte on the limit cycle wins and the frame completes
    send(8'hFE); send(8'h02);
    repeat (19) @(negedge clk);
    send(8'h04);
    check("tmo_edge.no_err", 64'(bus.frame_err), 64'd0);
    check("tmo_edge.busy",   64'(bus.busy), 64'd1);
    send(8'h77);
    send(8'hEF);
    expect_frame("tmo_edge", 8'h04, 4'd1, 64'h77);
    @(negedge clk);

    // Garbage: stray byte, then a header taken as L=FE, then ignored bytes
    send(8'h00);
    check("garb.idle", 64'(bus.busy), 64'd0);
    send(8'hFE); send(8'hFE);
    expect_err("garb", 2'd1);
    seen = 1'b0;
    send(8'h01); seen = seen | bus.cmd_valid | bus.frame_err | bus.busy;
    send(8'h02); seen = seen | bus.cmd_valid | bus.frame_err | bus.busy;
    send(8'hEF); seen = seen | bus.cmd_valid | bus.frame_err | bus.busy;
    check("garb.ignored", 64'(seen), 64'd0);
    check("garb.err_code_held", 64'(bus.err_code), 64'd1);

    // Reset in DATA, then a clean frame
    send(8'hFE); send(8'h03); send(8'h02); send(8'h55);
    check("rstmid.busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rstmid.cmd_code", 64'(bus.cmd_code), 64'd0);
    check("rstmid.payload",  bus.payload, 64'd0);
    check("rstmid.len",      64'(bus.payload_len), 64'd0);
    check("rstmid.err_code", 64'(bus.err_code), 64'd0);
    check("rstmid.busy0",    64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid.no_pulse", 64'(bus.cmd_valid | bus.frame_err), 64'd0);
    send(8'hFE); send(8'h03); send(8'h02); send(8'h55); send(8'h66); send(8'hEF);
    expect_frame("post_rst", 8'h02, 4'd2, 64'h6655);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
